uart_fifo: RTL
==============

// Module: uart_fifo
//
// PURPOSE
//   Synchronous FIFO that buffers bytes on either side of the UART core.
//   RX side: wr <- rx_done_tick, w_data <- dout.
//   TX side: r_data -> din; rd and tx_start both driven from tx_done_tick/!empty.
//   First-word-fall-through: the head entry is visible on r_data without a read strobe.
//   Adds occupancy count and sticky overflow/underflow flags for host diagnostics.
//
// PARAMETERS
//   DBIT        8   data word width; matches the UART DBIT
//   ADDR_WIDTH  4   depth = 2**ADDR_WIDTH entries (default 16)
//
// PORTS
//   clk        in   1             system clock, rising edge
//   rst        in   1             asynchronous reset, active-high
//   wr         in   1             write strobe, 1-cycle pulse per word
//   w_data     in   DBIT          write data, sampled when wr=1
//   rd         in   1             read strobe; pops the head entry
//   r_data     out  DBIT          head entry (FWFT); 0 when empty
//   empty      out  1             no entries stored
//   full       out  1             2**ADDR_WIDTH entries stored
//   count      out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH
//   ovf        out  1             sticky: a write was attempted while full
//   udf        out  1             sticky: a read was attempted while empty
//   clr_err    in   1             synchronous clear of ovf and udf
//
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - w_ptr = r_ptr = 0, count = 0.
//   - empty = 1, full = 0, ovf = udf = 0, r_data = 0.
//   - Storage array is not reset.
// - Pointers are ADDR_WIDTH bits and wrap naturally 2**ADDR_WIDTH-1 -> 0.
// - empty/full/count are registered; they update on the same edge that commits the op.
// - Write only (wr=1, rd=0):
//   - !full: mem[w_ptr] <= w_data, w_ptr+1, count+1.
//   - full: write dropped; pointers and count unchanged; ovf <= 1.
// - Read only (rd=1, wr=0):
//   - !empty: r_ptr+1, count-1.
//   - empty: read ignored; udf <= 1.
// - Simultaneous wr & rd:
//   - empty: write only; count becomes 1; udf is not set.
//   - full: both performed; count stays at full; ovf is not set.
//   - otherwise: both performed; count unchanged.
// - r_data = empty ? 0 : mem[r_ptr], combinational from the registered state.
//   - Latency: a word written at edge N appears on r_data after edge N, when the FIFO was empty.
// - full = (count == 2**ADDR_WIDTH); empty = (count == 0); never both 1.
// - clr_err clears ovf/udf at the next edge.
//   - If an error event occurs in the same cycle, the set wins.
// - Reset mid-operation discards all contents immediately; no partial-state recovery.
//
// TESTING
// - Reset -> empty=1, full=0, count=0, r_data=0, ovf=udf=0.
// - Write 0xA5 then 0x3C (1 cycle apart):
//   -> r_data=0xA5 the cycle after the first write; count=2.
//   -> rd once -> r_data=0x3C, count=1.
// - Write 16 words 0x00..0x0F:
//   -> full=1, count=16.
//   -> 17th write 0xFF -> dropped, ovf=1.
//   -> drain 16 reads -> sequence 0x00..0x0F, empty=1.
// - Full FIFO + wr&rd in the same cycle (w_data=0x77):
//   -> count stays 16, ovf=0, head advances.
//   -> 0x77 is read out last.
// - Empty FIFO:
//   - rd alone -> udf=1, count=0.
//   - wr&rd together (0x5A) -> count=1, r_data=0x5A, udf unchanged.
//   - clr_err -> ovf=udf=0.
// - Wrap and reset:
//   - 40 random interleaved ops vs scoreboard model, pointer wrap checked.
//   - Assert rst mid-burst -> all outputs at reset values next sample.

Source files
------------

// File: rtl/uart_fifo.sv
// uart_fifo: first-word-fall-through byte FIFO for the UART RX/TX paths.
// Revision 1.0 - registered occupancy/flags plus sticky overflow/underflow diagnostics.
`default_nettype none

module uart_fifo #(
  parameter int DBIT       = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DBIT-1:0]       w_data,
  input  logic                  rd,
  output logic [DBIT-1:0]       r_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ovf,
  output logic                  udf,
  input  logic                  clr_err
);

  localparam int                DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DBIT-1:0]       r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_w_ptr;
  logic [ADDR_WIDTH-1:0] r_r_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_do_wr;
  logic                  w_do_rd;
  logic                  w_ovf_set;
  logic                  w_udf_set;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  // A full FIFO still accepts a write when a read frees the head slot on the same edge.
  assign w_do_wr   = wr & (~r_full | rd);
  assign w_do_rd   = rd & ~r_empty;
  assign w_ovf_set = wr & r_full & ~rd;
  assign w_udf_set = rd & r_empty & ~wr;

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_wr && !w_do_rd) begin
      w_count_nxt = r_count + (ADDR_WIDTH + 1)'(1);
    end else if (w_do_rd && !w_do_wr) begin
      w_count_nxt = r_count - (ADDR_WIDTH + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_w_ptr] <= w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w_ptr <= '0;
      r_r_ptr <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_do_wr) begin
        r_w_ptr <= r_w_ptr + ADDR_WIDTH'(1);
      end
      if (w_do_rd) begin
        r_r_ptr <= r_r_ptr + ADDR_WIDTH'(1);
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == C_FULL);
      // An error event in the same cycle as clr_err keeps its flag set.
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (clr_err) begin
        r_ovf <= 1'b0;
      end
      if (w_udf_set) begin
        r_udf <= 1'b1;
      end else if (clr_err) begin
        r_udf <= 1'b0;
      end
    end
  end

  assign r_data = r_empty ? '0 : r_mem[r_r_ptr];
  assign empty  = r_empty;
  assign full   = r_full;
  assign count  = r_count;
  assign ovf    = r_ovf;
  assign udf    = r_udf;

endmodule

`default_nettype wire
